// File: rtl/inst_assembler_pkg.sv
// Shared constants for the RV32I field-level encoder: optype codes (also used by
// the instruction decoder) and base opcodes.
package inst_assembler_pkg;

    localparam logic [2:0] OP_R = 3'd0;
    localparam logic [2:0] OP_I = 3'd1;
    localparam logic [2:0] OP_S = 3'd2;
    localparam logic [2:0] OP_B = 3'd3;
    localparam logic [2:0] OP_U = 3'd4;
    localparam logic [2:0] OP_J = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

endpackage

// File: rtl/inst_assembler_fifo.sv
// Small synchronous FIFO with a separate occupancy counter and a synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    // Storage is not reset; only pointers and occupancy matter.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/inst_assembler.sv
// Packs decoded RV32I fields into instruction words, buffers them and streams
// them into IMEM at consecutive word addresses.
module inst_assembler
    import inst_assembler_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 1024,
    localparam int         WW        = $clog2(MAX_WORDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_optype,
    input  logic [6:0]    in_opcode,
    input  logic [2:0]    in_funct3,
    input  logic [6:0]    in_funct7,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [4:0]    in_rd,
    input  logic [31:0]   in_imm,
    output logic          mem_we,
    input  logic          mem_ready,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [WW-1:0] words,
    output logic          done,
    output logic          err
);

    function automatic logic [31:0] pack_word(
        input logic [2:0]  t,
        input logic [6:0]  opc,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  rd,
        input logic [31:0] imm
    );
        logic [31:0] w;
        w = '0;
        case (t)
            OP_R:    w = {f7, rs2, rs1, f3, rd, opc};
            OP_I:    w = {imm[11:0], rs1, f3, rd, opc};
            OP_S:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            OP_B:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            OP_U:    w = {imm[31:12], rd, opc};
            OP_J:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            default: w = '0;
        endcase
        return w;
    endfunction

    logic        fifo_full, fifo_empty;
    logic [31:0] fifo_dout, packed_word;
    logic [$clog2(DEPTH+1)-1:0] fifo_count_unused;
    logic        accept, bad, push, pop;

    // Undefined optypes and odd branch/jump offsets cannot be encoded.
    assign bad = (in_optype > OP_J) ||
                 (((in_optype == OP_B) || (in_optype == OP_J)) && in_imm[0]);

    assign in_ready    = !rst && !fifo_full && !done && !clear;
    assign accept      = in_valid && in_ready;
    assign push        = accept && !bad;
    assign mem_we      = !fifo_empty && !done;
    assign pop         = mem_we && mem_ready && !clear;
    assign mem_wdata   = mem_we ? fifo_dout : '0;
    assign mem_addr    = BASE_ADDR + (32'(words) << 2);
    assign packed_word = pack_word(in_optype, in_opcode, in_funct3, in_funct7,
                                   in_rs1, in_rs2, in_rd, in_imm);

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (push),
        .pop   (pop),
        .din   (packed_word),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else if (clear) begin
            words <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            if (pop) begin
                words <= words + 1'b1;
                if (words == WW'(MAX_WORDS - 1)) done <= 1'b1;
            end
            if (accept && bad) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_assembler.sv
// Randomized scoreboard bench for inst_assembler with a field-arithmetic encoder model.
module tb_inst_assembler;
    import inst_assembler_pkg::*;

    localparam int          DEPTH = 4;
    localparam int          MAXW  = 6;
    localparam int          WW    = $clog2(MAXW + 1);
    localparam logic [31:0] BASE  = 32'h0000_0100;

    typedef struct {
        logic [2:0]  t;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
    } bundle_t;

    logic clk, rst, clear, in_valid, in_ready, mem_we, mem_ready, done, err;
    logic [2:0]  in_optype, in_funct3;
    logic [6:0]  in_opcode, in_funct7;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm, mem_addr, mem_wdata;
    logic [WW-1:0] words;

    logic [31:0] exp_q[$];
    int  exp_words = 0;
    bit  exp_err = 0;
    int  n_chk = 0, n_fail = 0;
    bit  rnd_ready = 0;
    logic ready_req = 0;

    inst_assembler #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_optype(in_optype), .in_opcode(in_opcode), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .words(words), .done(done), .err(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 mem_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_req;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference encoder: place each immediate slice by shift-and-mask arithmetic.
    function automatic logic [31:0] ref_word(input bundle_t b);
        logic [31:0] base, i;
        base = 32'(b.opc) | (32'(b.f3) << 12) | (32'(b.rs1) << 15);
        i = b.imm;
        case (b.t)
            3'd0: return base | (32'(b.rd) << 7) | (32'(b.rs2) << 20) | (32'(b.f7) << 25);
            3'd1: return base | (32'(b.rd) << 7) | ((i & 32'hFFF) << 20);
            3'd2: return base | (32'(b.rs2) << 20) | ((i & 32'h1F) << 7) | (((i >> 5) & 32'h7F) << 25);
            3'd3: return base | (32'(b.rs2) << 20) | (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3F) << 25)
                        | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 1) << 7);
            3'd4: return 32'(b.opc) | (32'(b.rd) << 7) | (i & 32'hFFFF_F000);
            default: return 32'(b.opc) | (32'(b.rd) << 7) | (((i >> 20) & 1) << 31)
                        | (((i >> 1) & 32'h3FF) << 21) | (((i >> 11) & 1) << 20) | (((i >> 12) & 32'hFF) << 12);
        endcase
    endfunction

    function automatic bit is_drop(input bundle_t b);
        return (b.t > 3'd5) || (((b.t == 3'd3) || (b.t == 3'd5)) && b.imm[0]);
    endfunction

    function automatic bundle_t rnd_b(input bit allow_drop);
        bundle_t b;
        b.t   = allow_drop ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
        b.opc = 7'($urandom); b.f3 = 3'($urandom); b.f7 = 7'($urandom);
        b.rs1 = 5'($urandom); b.rs2 = 5'($urandom); b.rd = 5'($urandom);
        b.imm = $urandom;
        if (!allow_drop && (b.t == 3'd3 || b.t == 3'd5)) b.imm[0] = 1'b0;
        return b;
    endfunction

    function automatic bundle_t mk(input logic [2:0] t, input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                   input logic [31:0] imm);
        bundle_t b;
        b.t = t; b.opc = opc; b.f3 = f3; b.f7 = 7'd0;
        b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.imm = imm;
        return b;
    endfunction

    // Scoreboard monitor: every completed write must match the queue head.
    always @(negedge clk) begin
        if (!rst && !clear) begin
            chk("words", 32'(words), 32'(exp_words));
            chk("done", done, exp_words == MAXW);
            if (exp_words == MAXW) chk("we_after_done", mem_we, 0);
            else if (mem_we && mem_ready) begin
                if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    chk("wdata", mem_wdata, exp_q[0]);
                    chk("addr", mem_addr, BASE + 32'(4 * exp_words));
                    void'(exp_q.pop_front());
                    exp_words++;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bundle_t b, input bit use_lit, input logic [31:0] lit);
        bit acc = 0;
        in_optype = b.t; in_opcode = b.opc; in_funct3 = b.f3; in_funct7 = b.f7;
        in_rs1 = b.rs1; in_rs2 = b.rs2; in_rd = b.rd; in_imm = b.imm;
        in_valid = 1;
        for (int k = 0; k < 60 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                if (is_drop(b)) exp_err = 1;
                else exp_q.push_back(use_lit ? lit : ref_word(b));
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_left", 32'(exp_q.size()), 0);
    endtask

    task automatic do_clear();
        clear = 1;
        @(negedge clk);
        chk("ready_in_clear", in_ready, 0);
        @(posedge clk); #1;
        clear = 0;
        exp_q.delete(); exp_words = 0; exp_err = 0;
        chk("clr_words", 32'(words), 0);
        chk("clr_done", done, 0);
        chk("clr_err", err, 0);
        chk("clr_addr", mem_addr, BASE);
        chk("clr_we", mem_we, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, BASE);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_words"}, 32'(words), 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        logic [31:0] head;
        rst = 1; clear = 0; in_valid = 0; mem_ready = 0;
        in_optype = 0; in_opcode = 0; in_funct3 = 0; in_funct7 = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_imm = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        // add x3,x1,x2 with IMEM stalled: first-write latency and held port
        send(mk(OP_R, OPC_OP, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0), 1, 32'h002081B3);
        @(negedge clk);
        chk("r_we_latency", mem_we, 1);
        chk("r_wdata_hold", mem_wdata, 32'h002081B3);
        chk("r_addr_hold", mem_addr, BASE);
        ready_req = 1;
        drain();
        chk("r_words", 32'(words), 1);

        // beq x1,x2,-8 and jal x1,+2048
        send(mk(OP_B, OPC_BRANCH, 3'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8), 1, 32'hFE208CE3);
        send(mk(OP_J, OPC_JAL, 3'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0800), 1, 32'h001000EF);
        drain();

        // Back-pressure: four fill the FIFO, fifth waits for the first write
        do_clear();
        ready_req = 0;
        @(posedge clk); #1;
        for (int n = 0; n < 4; n++) send(rnd_b(0), 0, 0);
        @(negedge clk);
        chk("bp_ready_low", in_ready, 0);
        head = exp_q[0];
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("bp_we", mem_we, 1);
            chk("bp_wdata", mem_wdata, head);
            chk("bp_addr", mem_addr, BASE);
        end
        @(posedge clk); #1;
        fork
            send(rnd_b(0), 0, 0);
            begin repeat (4) @(posedge clk); ready_req = 1; end
        join
        drain();
        chk("bp_words", 32'(words), 5);

        // Drops: undefined optype, odd branch offset; a good I-type still goes through
        do_clear();
        begin
            bundle_t b;
            b = rnd_b(0); b.t = 3'd6;
            send(b, 0, 0);
        end
        send(mk(OP_B, OPC_BRANCH, 3'd1, 5'd4, 5'd5, 5'd0, 32'd3), 0, 0);
        @(posedge clk); #1;
        chk("drop_err", err, 1);
        chk("drop_words", 32'(words), 0);
        chk("drop_we", mem_we, 0);
        send(mk(OP_I, OPC_OPIMM, 3'd0, 5'd2, 5'd0, 5'd7, 32'hFFFF_F801), 0, 0);
        drain();
        chk("drop_i_words", 32'(words), 1);
        chk("drop_err_sticky", err, 1);

        // Limit: leftover entries are discarded once done
        do_clear();
        for (int n = 0; n < 5; n++) send(rnd_b(0), 0, 0);
        drain();
        ready_req = 0;
        @(posedge clk); #1;
        for (int n = 0; n < 3; n++) send(rnd_b(0), 0, 0);
        ready_req = 1;
        repeat (8) @(posedge clk);
        #1;
        chk("lim_done", done, 1);
        chk("lim_ready", in_ready, 0);
        chk("lim_words", 32'(words), MAXW);
        chk("lim_we", mem_we, 0);
        chk("lim_leftover", 32'(exp_q.size()), 2);
        do_clear();
        send(rnd_b(0), 0, 0);
        drain();

        // Randomized rounds with random IMEM stalls and drop cases
        for (int r = 0; r < 12; r++) begin
            do_clear();
            rnd_ready = 1;
            for (int n = 0; n < 4; n++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send(rnd_b(1), 0, 0);
            end
            rnd_ready = 0; ready_req = 1;
            drain();
            @(posedge clk); #1;
            chk("rnd_err", err, exp_err);
        end

        // Reset with two entries pending and IMEM stalled
        do_clear();
        ready_req = 0;
        @(posedge clk); #1;
        send(rnd_b(0), 0, 0);
        send(rnd_b(0), 0, 0);
        @(negedge clk);
        chk("pre_rst_we", mem_we, 1);
        rst = 1;
        #1;
        chk_reset_vals("mid_rst");
        @(posedge clk); #1;
        rst = 0;
        exp_q.delete(); exp_words = 0; exp_err = 0;
        @(negedge clk);
        chk("post_rst_we", mem_we, 0);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_addr", mem_addr, BASE);
        chk("post_rst_words", 32'(words), 0);
        @(posedge clk); #1;
        ready_req = 1;
        send(rnd_b(0), 0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_assembler.md
Name: inst_assembler

Overview:
- Encoder side of the instruction-field format: takes decoded fields (opcode, funct3, funct7, rs1, rs2, rd, optype) plus an immediate, and packs them into a 32-bit RV32I word.
- Buffers the packed words in a small FIFO, then writes them sequentially into instruction memory through a stallable write port.
- Used by the boot/loader path and by testbenches to build IMEM images from field-level descriptions.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- BASE_ADDR, 32'h0000_0000, byte address of the first IMEM write.
- MAX_WORDS, 1024, number of IMEM writes before the block reports done.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart: empties the FIFO, reloads the address, clears done and err.
- in_valid  in  1  field bundle is valid.
- in_ready  out  1  block can accept a bundle.
- in_optype  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J.
- in_opcode  in  7  opcode; copied to word bits [6:0].
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7.
- in_rs1  in  5  rs1.
- in_rs2  in  5  rs2.
- in_rd  in  5  rd.
- in_imm  in  32  immediate, byte-offset semantics.
- mem_we  out  1  write request to IMEM.
- mem_ready  in  1  IMEM accepts the write this cycle.
- mem_addr  out  32  byte address of the write.
- mem_wdata  out  32  packed instruction word.
- words  out  clog2(MAX_WORDS+1)  count of completed IMEM writes.
- done  out  1  set once words == MAX_WORDS.
- err  out  1  sticky flag: a bundle was dropped.

Behaviour:
- Reset values: in_ready=0 while rst is asserted, 1 on the first cycle after release; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; words=0; done=0; err=0; FIFO empty.
- Accept rule: a bundle is accepted when in_valid && in_ready.
- in_ready = !fifo_full && !done && !clear. While the FIFO is full, in_ready stays 0 even if a pop happens in the same cycle (no same-cycle refill).
- Packing (combinational), bit fields MSB to LSB:
  - R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
  - I: imm[11:0] | rs1 | funct3 | rd | opcode.
  - S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
  - U: imm[31:12] | rd | opcode.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode.
  - Fields that a format does not use are ignored.
- Drop rules: optype 6 or 7, or B/J with imm[0]=1, is accepted (handshake completes), nothing is pushed, and err is set. err stays set until rst or clear.
- Latency: a bundle accepted at edge N is in the FIFO after edge N. mem_we=1 from cycle N+1 at the earliest.
- Memory write port:
  - mem_we = FIFO non-empty && !done.
  - mem_wdata is the FIFO head.
  - mem_addr = BASE_ADDR + 4*words.
  - A write completes on an edge where mem_we && mem_ready. That edge pops the head and increments words.
  - While mem_ready=0, mem_we, mem_addr and mem_wdata hold stable.
- Simultaneous push and pop when the FIFO is not full: occupancy is unchanged and ordering is preserved.
- FIFO pointers wrap modulo DEPTH. Occupancy is tracked in a separate counter of width clog2(DEPTH+1).
- done: set on the edge where words reaches MAX_WORDS. After that, in_ready=0 and mem_we=0, and any leftover FIFO entries are discarded (not written) until clear.
- clear takes priority over a same-cycle push or pop. Its effects appear on the next edge; words and err are zeroed.
- rst mid-transfer: all state returns to reset values immediately. No partial write is guaranteed; IMEM must ignore the write cycle during reset.

Decomposition:
- Shared package:
  - OP_R..OP_J optype constants (values 0..5), shared with the instruction decoder.
  - RV32I opcode constants.
- Sub-module sync_fifo: parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, count.
- The packing function lives in the top level.

Test Plan:
- R-type: add x3,x1,x2 (optype=0, opcode=7'h33, rs1=1, rs2=2, rd=3, funct3=0, funct7=0) -> mem_wdata=32'h002081B3, mem_addr=BASE_ADDR, words=1 after the write.
- B-type beq x1,x2,-8 (imm=32'hFFFF_FFF8, funct3=0, opcode=7'h63) -> 32'hFE208CE3. J-type jal x1,+2048 -> 32'h001000EF.
- Back-pressure: hold mem_ready=0 and push 5 bundles with DEPTH=4 -> in_ready drops after the 4th and mem_* hold steady. Release mem_ready -> 4 writes at addresses 0,4,8,12 in input order, then the 5th bundle is accepted.
- Drop: optype=6, then B-type with imm=3 -> err=1, words unchanged, nothing pushed. A following valid I-type is still written.
- Limit: MAX_WORDS=2, push 3 bundles -> done=1 after 2 writes, in_ready=0, third bundle not written. clear -> words=0, done=0, mem_addr=BASE_ADDR.
- Reset while the FIFO holds 2 entries and mem_ready=0 -> mem_we=0 and all outputs at reset values during reset and after release.
